// File: rtl/mem_controller_if.sv
// Bus bundle between the core, mem_controller and main_memory.
// The slave modport is the controller's view; master is the core/memory side.
interface mem_controller_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic              req_burst;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;

    logic              resp_valid;
    logic [DATA_W-1:0] resp_data;
    logic              resp_last;

    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data_in;
    logic              mem_write_enable;
    logic              mem_read_enable;
    logic [DATA_W-1:0] mem_data_out;

    modport slave (
        input  req_valid, req_write, req_burst, req_addr, req_wdata, mem_data_out,
        output req_ready, resp_valid, resp_data, resp_last,
               mem_address, mem_data_in, mem_write_enable, mem_read_enable
    );

    modport master (
        output req_valid, req_write, req_burst, req_addr, req_wdata, mem_data_out,
        input  req_ready, resp_valid, resp_data, resp_last,
               mem_address, mem_data_in, mem_write_enable, mem_read_enable
    );
endinterface

// File: rtl/mem_controller.sv
// Core-to-memory access unit: single load/store and fixed-length burst reads,
// absorbing the memory's one-cycle registered read latency.
module mem_controller #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 16,
    parameter int BURST_LEN = 4
) (
    input  logic               clk,
    input  logic               reset,
    mem_controller_if.slave    bus
);
    localparam int CNT_W = $clog2(BURST_LEN + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] w_wdata_nxt;
    logic              r_we;
    logic              w_we_nxt;
    logic              r_re;
    logic              w_re_nxt;
    logic [CNT_W-1:0]  r_beats;
    logic [CNT_W-1:0]  w_beats_nxt;
    logic              r_rd_pend;
    logic              w_rd_pend_nxt;
    logic              r_rd_last;
    logic              w_rd_last_nxt;
    logic              r_resp_valid;
    logic              w_resp_valid_nxt;
    logic              r_resp_last;
    logic              w_resp_last_nxt;
    logic [DATA_W-1:0] r_resp_data;
    logic [DATA_W-1:0] w_resp_data_nxt;
    logic              w_req_ready;

    assign w_req_ready = (r_state == IDLE);

    // Next-state, memory pin and response computation.
    always_comb begin
        w_state_nxt      = r_state;
        w_addr_nxt       = r_addr;
        w_wdata_nxt      = r_wdata;
        w_we_nxt         = r_we;
        w_re_nxt         = r_re;
        w_beats_nxt      = r_beats;
        // The memory samples whatever enable is presented at this edge.
        w_rd_pend_nxt    = r_re;
        w_rd_last_nxt    = r_re && (r_beats == CNT_W'(1));
        w_resp_valid_nxt = 1'b0;
        w_resp_last_nxt  = 1'b0;
        w_resp_data_nxt  = r_resp_data;

        if (r_rd_pend) begin
            w_resp_valid_nxt = 1'b1;
            w_resp_last_nxt  = r_rd_last;
            w_resp_data_nxt  = bus.mem_data_out;
        end else if (r_state == WRITE) begin
            w_resp_valid_nxt = 1'b1;
            w_resp_last_nxt  = 1'b1;
            w_resp_data_nxt  = {DATA_W{1'b0}};
        end else begin
            w_resp_valid_nxt = 1'b0;
            w_resp_last_nxt  = 1'b0;
        end

        case (r_state)
            IDLE: begin
                if (bus.req_valid && w_req_ready) begin
                    w_addr_nxt  = bus.req_addr;
                    w_wdata_nxt = bus.req_wdata;
                    if (bus.req_write) begin
                        w_we_nxt    = 1'b1;
                        w_state_nxt = WRITE;
                    end else begin
                        w_re_nxt    = 1'b1;
                        w_beats_nxt = bus.req_burst ? CNT_W'(BURST_LEN) : CNT_W'(1);
                        w_state_nxt = READ;
                    end
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            WRITE: begin
                w_we_nxt    = 1'b0;
                w_re_nxt    = 1'b0;
                w_state_nxt = IDLE;
            end
            READ: begin
                if (r_beats == CNT_W'(1)) begin
                    w_re_nxt    = 1'b0;
                    w_beats_nxt = CNT_W'(0);
                    w_state_nxt = DRAIN;
                end else begin
                    w_addr_nxt  = r_addr + ADDR_W'(1);
                    w_beats_nxt = r_beats - CNT_W'(1);
                    w_state_nxt = READ;
                end
            end
            DRAIN: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_we_nxt    = 1'b0;
                w_re_nxt    = 1'b0;
                w_beats_nxt = CNT_W'(0);
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any burst in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_addr       <= {ADDR_W{1'b0}};
            r_wdata      <= {DATA_W{1'b0}};
            r_we         <= 1'b0;
            r_re         <= 1'b0;
            r_beats      <= CNT_W'(0);
            r_rd_pend    <= 1'b0;
            r_rd_last    <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_last  <= 1'b0;
            r_resp_data  <= {DATA_W{1'b0}};
        end else begin
            r_state      <= w_state_nxt;
            r_addr       <= w_addr_nxt;
            r_wdata      <= w_wdata_nxt;
            r_we         <= w_we_nxt;
            r_re         <= w_re_nxt;
            r_beats      <= w_beats_nxt;
            r_rd_pend    <= w_rd_pend_nxt;
            r_rd_last    <= w_rd_last_nxt;
            r_resp_valid <= w_resp_valid_nxt;
            r_resp_last  <= w_resp_last_nxt;
            r_resp_data  <= w_resp_data_nxt;
        end
    end

    assign bus.req_ready        = w_req_ready;
    assign bus.resp_valid       = r_resp_valid;
    assign bus.resp_last        = r_resp_last;
    assign bus.resp_data        = r_resp_data;
    assign bus.mem_address      = r_addr;
    assign bus.mem_data_in      = r_wdata;
    assign bus.mem_write_enable = r_we;
    assign bus.mem_read_enable  = r_re;
endmodule

// File: tb/tb_mem_controller.sv
// Bench for mem_controller: behavioural memory, a transaction-level reference
// model that predicts pin activity and responses per cycle, directed plus random traffic.
module tb_mem_controller;
    localparam int DW = 16;
    localparam int AW = 16;
    localparam int BL = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mem_controller_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    mem_controller #(.DATA_W(DW), .ADDR_W(AW), .BURST_LEN(BL)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int busy_until = -1;
    int n_hs = 0;
    int n_sent = 0;

    typedef struct {
        int          cyc;
        logic [15:0] data;
        logic        last;
    } beat_t;

    beat_t       exp_q [$];
    logic [15:0] exp_re [int];
    logic [15:0] exp_we_a [int];
    logic [15:0] exp_we_d [int];
    logic [15:0] mem_arr [int];
    logic [15:0] ref_mem [int];

    logic        hs_pend = 1'b0;
    logic        hs_wr = 1'b0;
    logic        hs_bst = 1'b0;
    logic [15:0] hs_a = 16'h0;
    logic [15:0] hs_d = 16'h0;

    function automatic logic [15:0] init_val(input logic [15:0] a);
        logic [15:0] p;
        p = a * 16'h9E37;
        return p ^ 16'h5A5A;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Memory with one-cycle registered read.
    always @(posedge clk) begin
        if (bus.mem_write_enable)
            mem_arr[int'(bus.mem_address)] = bus.mem_data_in;
        if (bus.mem_read_enable)
            bus.mem_data_out <= mem_arr.exists(int'(bus.mem_address)) ?
                                mem_arr[int'(bus.mem_address)] : init_val(bus.mem_address);
    end

    // Reference model: on each accepted request, predict pins and responses by cycle.
    always @(posedge clk) begin
        int n_v;
        logic [15:0] ai_v;
        cyc++;
        if (!reset && hs_pend) begin
            n_hs++;
            if (hs_wr) begin
                ref_mem[int'(hs_a)] = hs_d;
                exp_we_a[cyc] = hs_a;
                exp_we_d[cyc] = hs_d;
                exp_q.push_back('{cyc: cyc + 1, data: 16'h0000, last: 1'b1});
                busy_until = cyc;
            end else begin
                n_v = hs_bst ? BL : 1;
                for (int i = 0; i < n_v; i++) begin
                    ai_v = hs_a + 16'(i);
                    exp_re[cyc + i] = ai_v;
                    exp_q.push_back('{cyc: cyc + 2 + i,
                                      data: ref_mem.exists(int'(ai_v)) ? ref_mem[int'(ai_v)] : init_val(ai_v),
                                      last: (i == n_v - 1)});
                end
                busy_until = cyc + n_v;
            end
        end
    end

    // Per-cycle comparison of pins and responses against the prediction.
    always @(negedge clk) begin
        logic ev;
        chk("rd_wr_exclusive", bus.mem_read_enable && bus.mem_write_enable, 32'd0);
        chk("req_ready", bus.req_ready, (cyc > busy_until));
        chk("mem_read_enable", bus.mem_read_enable, exp_re.exists(cyc));
        if (exp_re.exists(cyc)) begin
            chk("rd_address", bus.mem_address, exp_re[cyc]);
            exp_re.delete(cyc);
        end
        chk("mem_write_enable", bus.mem_write_enable, exp_we_a.exists(cyc));
        if (exp_we_a.exists(cyc)) begin
            chk("wr_address", bus.mem_address, exp_we_a[cyc]);
            chk("wr_data", bus.mem_data_in, exp_we_d[cyc]);
            exp_we_a.delete(cyc);
            exp_we_d.delete(cyc);
        end
        ev = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
        chk("resp_valid", bus.resp_valid, ev);
        if (ev) begin
            chk("resp_data", bus.resp_data, exp_q[0].data);
            chk("resp_last", bus.resp_last, exp_q[0].last);
            void'(exp_q.pop_front());
        end else begin
            chk("resp_last_idle", bus.resp_last, 32'd0);
        end
        hs_pend = bus.req_valid && bus.req_ready;
        hs_wr   = bus.req_write;
        hs_bst  = bus.req_burst;
        hs_a    = bus.req_addr;
        hs_d    = bus.req_wdata;
    end

    // Present a request and hold it until accepted; valid stays high afterwards.
    task automatic send(input logic wr, input logic bst, input logic [15:0] a, input logic [15:0] d);
        int t;
        logic hs;
        t = 0;
        n_sent++;
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_burst = bst;
        bus.req_addr  = a;
        bus.req_wdata = d;
        forever begin
            hs = bus.req_ready;
            @(posedge clk);
            #1;
            if (hs) break;
            t++;
            if (t >= 40) begin
                chk("send_accept", hs, 32'd1);
                break;
            end
        end
    endtask

    task automatic idle(input int n);
        bus.req_valid = 1'b0;
        bus.req_addr  = 16'($urandom);
        bus.req_wdata = 16'($urandom);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int t;
        logic [15:0] a;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_burst = 1'b0;
        bus.req_addr  = 16'h0;
        bus.req_wdata = 16'h0;
        #2;
        chk("rst_ready", bus.req_ready, 32'd1);
        chk("rst_re", bus.mem_read_enable, 32'd0);
        chk("rst_we", bus.mem_write_enable, 32'd0);
        chk("rst_resp_valid", bus.resp_valid, 32'd0);
        chk("rst_resp_last", bus.resp_last, 32'd0);
        chk("rst_resp_data", bus.resp_data, 32'd0);
        chk("rst_address", bus.mem_address, 32'd0);
        chk("rst_data_in", bus.mem_data_in, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;

        send(1'b1, 1'b0, 16'h0010, 16'hBEEF);
        idle(3);
        send(1'b0, 1'b0, 16'h0010, 16'h0000);
        idle(4);

        send(1'b1, 1'b0, 16'h0100, 16'h1111);
        send(1'b1, 1'b0, 16'h0101, 16'h2222);
        send(1'b1, 1'b0, 16'h0102, 16'h3333);
        send(1'b1, 1'b0, 16'h0103, 16'h4444);
        send(1'b0, 1'b1, 16'h0100, 16'h0000);
        idle(8);

        send(1'b1, 1'b0, 16'hFFFF, 16'hA5A5);
        send(1'b1, 1'b0, 16'h0000, 16'h5A5A);
        send(1'b0, 1'b1, 16'hFFFE, 16'h0000);
        idle(8);

        send(1'b1, 1'b0, 16'h0200, 16'hCAFE);
        send(1'b0, 1'b0, 16'h0200, 16'h0000);
        send(1'b0, 1'b1, 16'h01FF, 16'h0000);
        send(1'b0, 1'b0, 16'h0102, 16'h0000);
        idle(8);

        send(1'b0, 1'b1, 16'h0100, 16'h0000);
        bus.req_valid = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        reset = 1'b1;
        exp_q.delete();
        exp_re.delete();
        exp_we_a.delete();
        exp_we_d.delete();
        busy_until = -1;
        #1;
        chk("arst_re", bus.mem_read_enable, 32'd0);
        chk("arst_we", bus.mem_write_enable, 32'd0);
        chk("arst_resp_valid", bus.resp_valid, 32'd0);
        chk("arst_resp_last", bus.resp_last, 32'd0);
        chk("arst_ready", bus.req_ready, 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(2);
        send(1'b0, 1'b0, 16'h0101, 16'h0000);
        idle(4);

        repeat (40) begin
            case ($urandom_range(0, 2))
                0:       a = 16'h0300 + 16'($urandom_range(0, 15));
                1:       a = 16'hFFFD + 16'($urandom_range(0, 4));
                default: a = 16'($urandom);
            endcase
            send(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, 16'($urandom));
            if ($urandom_range(0, 2) == 0) idle($urandom_range(0, 3));
        end

        idle(0);
        t = 0;
        while (exp_q.size() > 0 && t < 100) begin
            @(posedge clk);
            t++;
        end
        @(negedge clk);
        #1;
        chk("drain_empty", exp_q.size(), 32'd0);
        chk("handshake_count", n_hs, n_sent);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
